// File: rtl/ctrl_pkg.sv
// Shared types and constants for the instruction-sequencing control FSM:
// state encodings, opcodes and ALU operation codes.
package ctrl_pkg;

    typedef enum logic [3:0] {
        S_INIT   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_NOOP   = 4'd3,
        S_LOAD_A = 4'd4,
        S_LOAD_B = 4'd5,
        S_STORE  = 4'd6,
        S_ADD    = 4'd7,
        S_SUB    = 4'd8,
        S_HALT   = 4'd9
    } state_t;

    localparam logic [3:0] OP_NOOP  = 4'h0;
    localparam logic [3:0] OP_STORE = 4'h1;
    localparam logic [3:0] OP_LOAD  = 4'h2;
    localparam logic [3:0] OP_ADD   = 4'h3;
    localparam logic [3:0] OP_SUB   = 4'h4;
    localparam logic [3:0] OP_HALT  = 4'h5;

    localparam logic [2:0] ALU_PASS_A = 3'b000;
    localparam logic [2:0] ALU_ADD    = 3'b001;
    localparam logic [2:0] ALU_SUB    = 3'b010;

    // Execute state entered from DECODE; unknown opcodes behave as NOOP.
    function automatic state_t op_to_state(input logic [3:0] op);
        case (op)
            OP_STORE: return S_STORE;
            OP_LOAD:  return S_LOAD_A;
            OP_ADD:   return S_ADD;
            OP_SUB:   return S_SUB;
            OP_HALT:  return S_HALT;
            default:  return S_NOOP;
        endcase
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Moore output decode: current state plus instruction fields to datapath controls.
// CTRL_LOAD_WAIT_EN splits the load into an address cycle and a write-back cycle.
module ctrl_decode
    import ctrl_pkg::*;
(
    input  state_t      state,
    input  logic [11:0] ir_fields,
    output logic        pc_clr,
    output logic        pc_up,
    output logic        ir_ld,
    output logic [7:0]  d_addr,
    output logic        d_wr,
    output logic        rf_s,
    output logic [3:0]  rf_w_addr,
    output logic [3:0]  rf_ra_addr,
    output logic [3:0]  rf_rb_addr,
    output logic        rf_w_en,
    output logic [2:0]  alu_s0
);

    always_comb begin
        pc_clr     = 1'b0;
        pc_up      = 1'b0;
        ir_ld      = 1'b0;
        d_addr     = 8'h00;
        d_wr       = 1'b0;
        rf_s       = 1'b0;
        rf_w_addr  = 4'h0;
        rf_ra_addr = 4'h0;
        rf_rb_addr = 4'h0;
        rf_w_en    = 1'b0;
        alu_s0     = ALU_PASS_A;
        case (state)
            S_INIT: pc_clr = 1'b1;
            S_FETCH: begin
                pc_up = 1'b1;
                ir_ld = 1'b1;
            end
`ifdef CTRL_LOAD_WAIT_EN
            // Address goes out first; write-back waits for the registered read.
            S_LOAD_A: d_addr = ir_fields[11:4];
            S_LOAD_B: begin
                d_addr    = ir_fields[11:4];
                rf_w_addr = ir_fields[3:0];
                rf_s      = 1'b1;
                rf_w_en   = 1'b1;
            end
`else
            S_LOAD_A: begin
                d_addr    = ir_fields[11:4];
                rf_w_addr = ir_fields[3:0];
                rf_s      = 1'b1;
                rf_w_en   = 1'b1;
            end
`endif
            S_STORE: begin
                d_addr     = ir_fields[7:0];
                rf_ra_addr = ir_fields[11:8];
                d_wr       = 1'b1;
            end
            S_ADD, S_SUB: begin
                rf_ra_addr = ir_fields[11:8];
                rf_rb_addr = ir_fields[7:4];
                rf_w_addr  = ir_fields[3:0];
                rf_w_en    = 1'b1;
                alu_s0     = (state == S_ADD) ? ALU_ADD : ALU_SUB;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/control_fsm.sv
// Instruction-sequencing control FSM: INIT -> FETCH -> DECODE -> execute -> FETCH.
// Define CTRL_LOAD_WAIT_EN for a two-cycle load (synchronous-read data memory).
module control_fsm
    import ctrl_pkg::*;
(
    input  logic        Clk,
    input  logic        Clr_n,
    input  logic        Run,
    input  logic [15:0] IR,
    output logic        PC_clr,
    output logic        PC_up,
    output logic        IR_ld,
    output logic [7:0]  D_addr,
    output logic        D_wr,
    output logic        RF_s,
    output logic [3:0]  RF_W_addr,
    output logic [3:0]  RF_Ra_addr,
    output logic [3:0]  RF_Rb_addr,
    output logic        RF_W_en,
    output logic [2:0]  ALU_s0,
    output logic [3:0]  outState
);

    state_t state_reg;

    always_ff @(posedge Clk or negedge Clr_n) begin
        if (!Clr_n) begin
            state_reg <= S_INIT;
        end else begin
            case (state_reg)
                S_INIT:   if (Run) state_reg <= S_FETCH;
                S_FETCH:  state_reg <= S_DECODE;
                S_DECODE: state_reg <= op_to_state(IR[15:12]);
`ifdef CTRL_LOAD_WAIT_EN
                S_LOAD_A: state_reg <= S_LOAD_B;
                S_LOAD_B: state_reg <= S_FETCH;
`else
                S_LOAD_A: state_reg <= S_FETCH;
`endif
                S_NOOP, S_STORE, S_ADD, S_SUB: state_reg <= S_FETCH;
                // Only Clr_n leaves HALT.
                S_HALT:   state_reg <= S_HALT;
                default:  state_reg <= S_INIT;
            endcase
        end
    end

    assign outState = state_reg;

    ctrl_decode u_decode (
        .state      (state_reg),
        .ir_fields  (IR[11:0]),
        .pc_clr     (PC_clr),
        .pc_up      (PC_up),
        .ir_ld      (IR_ld),
        .d_addr     (D_addr),
        .d_wr       (D_wr),
        .rf_s       (RF_s),
        .rf_w_addr  (RF_W_addr),
        .rf_ra_addr (RF_Ra_addr),
        .rf_rb_addr (RF_Rb_addr),
        .rf_w_en    (RF_W_en),
        .alu_s0     (ALU_s0)
    );

endmodule

// File: tb/tb_control_fsm.sv
// Directed scoreboard bench for control_fsm: expected output vectors are queued
// as stimulus is applied and checked one cycle later (or after an async reset).
module tb_control_fsm;

    logic        Clk = 1'b0;
    logic        Clr_n;
    logic        Run;
    logic [15:0] IR;
    logic        PC_clr, PC_up, IR_ld, D_wr, RF_s, RF_W_en;
    logic [7:0]  D_addr;
    logic [3:0]  RF_W_addr, RF_Ra_addr, RF_Rb_addr, outState;
    logic [2:0]  ALU_s0;

    control_fsm dut (
        .Clk        (Clk),
        .Clr_n      (Clr_n),
        .Run        (Run),
        .IR         (IR),
        .PC_clr     (PC_clr),
        .PC_up      (PC_up),
        .IR_ld      (IR_ld),
        .D_addr     (D_addr),
        .D_wr       (D_wr),
        .RF_s       (RF_s),
        .RF_W_addr  (RF_W_addr),
        .RF_Ra_addr (RF_Ra_addr),
        .RF_Rb_addr (RF_Rb_addr),
        .RF_W_en    (RF_W_en),
        .ALU_s0     (ALU_s0),
        .outState   (outState)
    );

    always #5 Clk = ~Clk;

    logic [32:0] obs;
    assign obs = {PC_clr, PC_up, IR_ld, D_addr, D_wr, RF_s, RF_W_addr,
                  RF_Ra_addr, RF_Rb_addr, RF_W_en, ALU_s0, outState};

    typedef struct {
        string       tag;
        logic [32:0] vec;
    } exp_t;

    exp_t sb_q[$];
    int   tests_run = 0;
    int   tests_failed = 0;
    int   pc_up_cnt;

    function automatic logic [32:0] ev(input logic pc_clr, input logic pc_up,
                                       input logic ir_ld, input logic [7:0] da,
                                       input logic dwr, input logic rfs,
                                       input logic [3:0] w, input logic [3:0] ra,
                                       input logic [3:0] rb, input logic wen,
                                       input logic [2:0] alu, input logic [3:0] st);
        return {pc_clr, pc_up, ir_ld, da, dwr, rfs, w, ra, rb, wen, alu, st};
    endfunction

    function automatic logic [32:0] ev_state(input logic [3:0] st);
        return ev(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 3'b000, st);
    endfunction

    task automatic check_pop();
        exp_t e;
        e = sb_q.pop_front();
        tests_run++;
        assert (obs === e.vec) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", e.tag, obs, e.vec);
        end
        $display("[TB] %-16s outState=%0d PC_up=%0b RF_W_en=%0b", e.tag, outState, PC_up, RF_W_en);
    endtask

    task automatic expect_now(input string tag, input logic [32:0] v);
        sb_q.push_back('{tag, v});
        check_pop();
    endtask

    task automatic cyc(input string tag, input logic [32:0] v);
        sb_q.push_back('{tag, v});
        @(posedge Clk);
        #1;
        pc_up_cnt += int'(PC_up);
        check_pop();
    endtask

    task automatic cmp_int(input string tag, input int o, input int e);
        tests_run++;
        assert (o === e) else begin
            tests_failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, o, e);
        end
        $display("[TB] %-16s value=%0d", tag, o);
    endtask

    logic [32:0] v_init, v_fetch, v_decode, v_noop, v_halt;

    initial begin
        v_init   = ev(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 3'b000, 4'd0);
        v_fetch  = ev(1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 3'b000, 4'd1);
        v_decode = ev_state(4'd2);
        v_noop   = ev_state(4'd3);
        v_halt   = ev_state(4'd9);
        pc_up_cnt = 0;

        Clr_n = 1'b0;
        Run   = 1'b0;
        IR    = 16'h0000;
        #2;
        expect_now("reset_init", v_init);
        Clr_n = 1'b1;
        cyc("idle_init", v_init);
        cyc("idle_init2", v_init);

        // ADD 3125
        Run = 1'b1;
        IR  = 16'h3125;
        pc_up_cnt = 0;
        cyc("add_fetch", v_fetch);
        Run = 1'b0;
        cyc("add_decode", v_decode);
        cyc("add_exec", ev(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 4'h5, 4'h1, 4'h2, 1'b1, 3'b001, 4'd7));
        cmp_int("add_pc_up_count", pc_up_cnt, 1);

        // STORE 1B44
        IR = 16'h1B44;
        pc_up_cnt = 0;
        cyc("store_fetch", v_fetch);
        cyc("store_decode", v_decode);
        cyc("store_exec", ev(1'b0, 1'b0, 1'b0, 8'h44, 1'b1, 1'b0, 4'h0, 4'hB, 4'h0, 1'b0, 3'b000, 4'd6));
        cmp_int("store_pc_up_count", pc_up_cnt, 1);

        // SUB 4789
        IR = 16'h4789;
        cyc("sub_fetch", v_fetch);
        cyc("sub_decode", v_decode);
        cyc("sub_exec", ev(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 4'h9, 4'h7, 4'h8, 1'b1, 3'b010, 4'd8));

        // LOAD 2A37
        IR = 16'h2A37;
        cyc("load_fetch", v_fetch);
        cyc("load_decode", v_decode);
`ifdef CTRL_LOAD_WAIT_EN
        cyc("load_a", ev(1'b0, 1'b0, 1'b0, 8'hA3, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 3'b000, 4'd4));
        cyc("load_b", ev(1'b0, 1'b0, 1'b0, 8'hA3, 1'b0, 1'b1, 4'h7, 4'h0, 4'h0, 1'b1, 3'b000, 4'd5));
`else
        cyc("load_a", ev(1'b0, 1'b0, 1'b0, 8'hA3, 1'b0, 1'b1, 4'h7, 4'h0, 4'h0, 1'b1, 3'b000, 4'd4));
`endif

        // Illegal opcode F000 then explicit NOOP 0000
        IR = 16'hF000;
        cyc("illegal_fetch", v_fetch);
        cyc("illegal_decode", v_decode);
        cyc("illegal_noop", v_noop);
        IR = 16'h0000;
        cyc("noop_fetch", v_fetch);
        cyc("noop_decode", v_decode);
        cyc("noop_exec", v_noop);

        // HALT 5000, held 50 cycles with Run toggling
        IR = 16'h5000;
        cyc("halt_fetch", v_fetch);
        cyc("halt_decode", v_decode);
        cyc("halt_enter", v_halt);
        pc_up_cnt = 0;
        for (int i = 0; i < 50; i++) begin
            Run = ~Run;
            cyc("halt_hold", v_halt);
        end
        cmp_int("halt_pc_up_count", pc_up_cnt, 0);
        Run = 1'b0;
        Clr_n = 1'b0;
        #2;
        expect_now("halt_clr_async", v_init);
        Clr_n = 1'b1;
        cyc("init_after_halt", v_init);

        // Reset mid-ADD, then restart
        IR  = 16'h3125;
        Run = 1'b1;
        cyc("add2_fetch", v_fetch);
        Run = 1'b0;
        cyc("add2_decode", v_decode);
        cyc("add2_exec", ev(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 4'h5, 4'h1, 4'h2, 1'b1, 3'b001, 4'd7));
        Clr_n = 1'b0;
        #1;
        expect_now("rst_mid_add", v_init);
        #2;
        Clr_n = 1'b1;
        cyc("init_wait_run", v_init);
        Run = 1'b1;
        cyc("fetch_after_rst", v_fetch);
        Run = 1'b0;
        cyc("decode_after_rst", v_decode);

        cmp_int("scoreboard_empty", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
